stream_mux_rr: RTL and testbench

- Parametrised N-channel registered stream multiplexer with valid/ready handshakes on every input and on the output.
- Two select modes: manual (external sel picks the channel, as in the existing 2:1 selector) and round-robin arbitration across all requesting channels.
- Output is a single registered stage tagged with its source channel. It sits between several producer streams and one shared consumer datapath.

---
 rtl/stream_mux_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_rr.sv | 73 +++++++
 tb/tb_stream_mux_rr.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin stream multiplexer.
package stream_mux_pkg;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_RR     = 1'b1;
   localparam int   DEF_WIDTH   = 5;
   localparam int   DEF_N       = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter  int N    = 4,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] idx
);

   logic [SELW:0] cand;
   logic          found;

   // Scan N candidates starting at ptr; ptr is always < N so one subtract wraps.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (SELW+1)'(k);
         if (cand >= (SELW+1)'(N)) cand = cand - (SELW+1)'(N);
         if (!found && req[cand[SELW-1:0]]) begin
            found                    = 1'b1;
            grant[cand[SELW-1:0]]    = 1'b1;
            idx                      = cand[SELW-1:0];
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux with manual or round-robin channel selection.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int N     = DEF_N,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic               mode,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_chan,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [SELW-1:0]  ptr;
   logic [N-1:0]     rr_grant, man_grant, grant;
   logic [SELW-1:0]  rr_idx, win_idx;
   logic [WIDTH-1:0] win_data;
   logic             slot_free, xfer;

   rr_arbiter #(.N(N)) u_arb (
      .req   (in_valid),
      .ptr   (ptr),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   // Manual grant: one-hot on sel; an out-of-range sel matches no channel.
   always_comb begin
      man_grant = '0;
      for (int i = 0; i < N; i++) man_grant[i] = (sel == SELW'(i));
   end

   assign grant     = (mode == MODE_RR) ? rr_grant : man_grant;
   assign win_idx   = (mode == MODE_RR) ? rr_idx : sel;
   assign slot_free = !out_valid || out_ready;
   // Nothing is accepted while reset is held.
   assign in_ready  = grant & {N{slot_free & rst_n}};
   assign xfer      = |(in_valid & in_ready);

   // One-hot AND-OR data select from the granted channel.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) win_data = win_data | in_data[i*WIDTH +: WIDTH];
   end

   // Output register and RR pointer; pointer only advances on an RR transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_chan  <= win_idx;
         if (mode == MODE_RR)
            ptr <= (rr_idx == SELW'(N-1)) ? '0 : SELW'(rr_idx + 1'b1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: N=4 main instance, N=3 instance for out-of-range sel.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n, rst3_n;

   logic [19:0] in_data;
   logic [3:0]  in_valid, in_ready;
   logic        mode, out_ready, out_valid;
   logic [1:0]  sel, out_chan;
   logic [4:0]  out_data;

   logic [14:0] in_data3;
   logic [2:0]  in_valid3, in_ready3;
   logic        mode3, out_ready3, out_valid3;
   logic [1:0]  sel3, out_chan3;
   logic [4:0]  out_data3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(5), .N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_mux_rr #(.WIDTH(5), .N(3)) dut3 (
      .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
      .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the registered output triple of the N=4 instance.
   task automatic chk_out(input string tag, input logic v, input logic [1:0] c, input logic [4:0] d);
      chk({tag, ".valid"}, out_valid, v);
      chk({tag, ".chan"},  out_chan,  c);
      chk({tag, ".data"},  out_data,  d);
   endtask

   initial begin
      // ch0=10 ch1=11 ch2=15 ch3=13
      in_data   = {5'h13, 5'h15, 5'h11, 5'h10};
      in_valid  = 4'b1111;
      mode      = 1'b1;
      sel       = 2'd0;
      out_ready = 1'b1;
      rst_n     = 1'b0;
      in_data3  = {5'h1F, 5'h0A, 5'h01};
      in_valid3 = 3'b000;
      mode3     = 1'b0;
      sel3      = 2'd3;
      out_ready3 = 1'b1;
      rst3_n    = 1'b0;

      // Reset state with all channels valid
      #3;
      chk_out("rst", 1'b0, 2'd0, 5'h00);
      chk("rst.in_ready", in_ready, 4'b0000);
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      #1;
      chk("rr0.in_ready", in_ready, 4'b0001);

      // Round-robin, all valid: 0,1,2,3,0,1 back to back
      tick(); chk_out("rr.w0", 1'b1, 2'd0, 5'h10);
      tick(); chk_out("rr.w1", 1'b1, 2'd1, 5'h11);
      tick(); chk_out("rr.w2", 1'b1, 2'd2, 5'h15);
      tick(); chk_out("rr.w3", 1'b1, 2'd3, 5'h13);
      tick(); chk_out("rr.w4", 1'b1, 2'd0, 5'h10);
      tick(); chk_out("rr.w5", 1'b1, 2'd1, 5'h11);

      // ptr=2, sparse requests 1010: ch3, wrap, ch1, ch3
      in_valid = 4'b1010;
      #1; chk("sp.rdy3", in_ready, 4'b1000);
      tick(); chk_out("sp.w3", 1'b1, 2'd3, 5'h13);
      chk("sp.rdy1", in_ready, 4'b0010);
      tick(); chk_out("sp.w1", 1'b1, 2'd1, 5'h11);
      chk("sp.rdy3b", in_ready, 4'b1000);
      tick(); chk_out("sp.w3b", 1'b1, 2'd3, 5'h13);

      // Backpressure: ptr now 0, output held, nothing accepted
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      #1; chk("bp.in_ready", in_ready, 4'b0000);
      tick(); chk_out("bp.hold1", 1'b1, 2'd3, 5'h13);
      tick(); chk_out("bp.hold2", 1'b1, 2'd3, 5'h13);
      out_ready = 1'b1;
      #1; chk("bp.release", in_ready, 4'b0001);
      tick(); chk_out("bp.fill", 1'b1, 2'd0, 5'h10);

      // Manual mode: sel=2 then sel=3; ptr stays 1
      mode = 1'b0;
      sel  = 2'd2;
      #1; chk("man.rdy2", in_ready, 4'b0100);
      tick(); chk_out("man.w2", 1'b1, 2'd2, 5'h15);
      sel = 2'd3;
      #1; chk("man.rdy3", in_ready, 4'b1000);
      tick(); chk_out("man.w3", 1'b1, 2'd3, 5'h13);
      mode = 1'b1;
      #1; chk("man.ptr_kept", in_ready, 4'b0010);

      // Drain to empty
      in_valid = 4'b0000;
      #1; chk("drain.in_ready", in_ready, 4'b0000);
      tick(); chk("drain.valid", out_valid, 1'b0);

      // N=3 with sel=3: no grant at all
      in_valid3 = 3'b111;
      #1; chk("n3.in_ready", in_ready3, 3'b000);
      tick(); chk("n3.valid1", out_valid3, 1'b0);
      tick(); chk("n3.valid2", out_valid3, 1'b0);

      // N=3: load ch1, stall, then async reset between edges
      sel3 = 2'd1;
      #1; chk("n3.rdy1", in_ready3, 3'b010);
      tick();
      chk("n3.w1.valid", out_valid3, 1'b1);
      chk("n3.w1.data",  out_data3,  5'h0A);
      chk("n3.w1.chan",  out_chan3,  2'd1);
      out_ready3 = 1'b0;
      tick();
      chk("n3.stall.data", out_data3, 5'h0A);
      #2;
      rst3_n = 1'b0;
      #1;
      chk("n3.arst.valid", out_valid3, 1'b0);
      chk("n3.arst.data",  out_data3,  5'h00);
      chk("n3.arst.chan",  out_chan3,  2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
